bram_port_arbiter: RTL
======================

# bram_port_arbiter

Round-robin arbiter sharing the native BRAM port B between `NUM_REQ` on-fabric requesters, such as DMA engines and inference kernels. Each requester issues single-word read or write commands over a valid/ready handshake. The arbiter issues at most one command per cycle to the BRAM. Read data returns in a fixed number of cycles, tagged back to the requester that issued it. The block sits between the kernels and the BRAM port B, while the AXI side of the BRAM controller stays untouched.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 10: word address width, matching BRAM depth 1024.
- `DATA_WIDTH`, default 32: data width, a multiple of 8.
- `RD_LATENCY`, default 1: BRAM read latency in cycles, 1 (no output register) or 2 (output register).

Ports:
- `aclk`  in  1: single clock for the block and for BRAM port B.
- `areset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`: command valid, one bit per requester.
- `req_ready`  out  `NUM_REQ`: command accepted (grant), one-hot or zero.
- `req_we`  in  `NUM_REQ`: 1 = write, 0 = read.
- `req_addr`  in  `NUM_REQ*ADDR_WIDTH`: word address; requester i occupies slice i.
- `req_wdata`  in  `NUM_REQ*DATA_WIDTH`: write data.
- `req_wstrb`  in  `NUM_REQ*DATA_WIDTH/8`: byte enables; ignored for reads.
- `rsp_valid`  out  `NUM_REQ`: read data valid for requester i, one-hot or zero.
- `rsp_rdata`  out  `DATA_WIDTH`: read data, shared by all requesters; qualified by `rsp_valid`.
- `bram_en`  out  1: port B enable.
- `bram_we`  out  `DATA_WIDTH/8`: port B byte write enables.
- `bram_addr`  out  `ADDR_WIDTH`: port B word address.
- `bram_wdata`  out  `DATA_WIDTH`: port B write data.
- `bram_rdata`  in  `DATA_WIDTH`: port B read data.

## Operation
- Arbitration is round-robin. `rr_ptr` (log2 `NUM_REQ` bits) holds the highest-priority index.
  - The search runs `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`. The first asserted `req_valid` wins.
  - After a grant to index g, `rr_ptr` becomes (g+1) mod `NUM_REQ`.
  - With no grant, `rr_ptr` holds.
- `req_ready` is combinational from `req_valid` and `rr_ptr`.
  - At most one bit is high per cycle, and only on a requester with `req_valid` high.
  - It is forced to 0 while `areset` is high.
  - A requester must hold its command stable until accepted.
- Accepted command: all BRAM outputs are registered from the winner's fields.
  - `bram_en` = 1.
  - `bram_we` = `req_wstrb` if write; 0 if read.
  - `bram_addr` and `bram_wdata` come from the winner's slices.
- No accept in a cycle:
  - `bram_en` = 0 and `bram_we` = 0.
  - `bram_addr` and `bram_wdata` hold their last values.
- Read tracking: a shift pipeline of depth `RD_LATENCY`+1 carries (valid, requester id) for reads only.
  - At the pipeline tail, `rsp_valid`[id] is asserted.
  - `rsp_rdata` is a pass-through of `bram_rdata`.
- Writes generate no response. A write is committed at the BRAM edge following acceptance.
- Ordering:
  - Commands reach the BRAM in acceptance order.
  - A read accepted after a write to the same address returns the new data, independent of the BRAM write mode.
- Responses cannot be backpressured. Every requester must accept `rsp_valid` in the cycle it is high.
- Reset values:
  - `req_ready` 0, `rsp_valid` 0, `bram_en` 0, `bram_we` 0.
  - `bram_addr` 0, `bram_wdata` 0.
  - `rr_ptr` 0, read-tracking pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and produce no `rsp_valid` after reset release. A write already driven to the BRAM completes or is lost depending on BRAM timing; the arbiter does not retry it.

## Timing
- Accept edge T: the edge at which `req_valid`[i] & `req_ready`[i] = 1.
- BRAM command is visible after edge T and sampled by the BRAM at edge T+1.
- Read data is on `bram_rdata` after edge T+`RD_LATENCY`.
- `rsp_valid`[i] is high for exactly one cycle, between edges T+`RD_LATENCY` and T+`RD_LATENCY`+1. The requester samples it at edge T+`RD_LATENCY`+1.
- Read latency from accept edge to sample edge is `RD_LATENCY`+1 cycles: 2 for the default, 3 for `RD_LATENCY`=2.
- Throughput is one command per cycle sustained, with no bubbles between different or identical requesters.
- Under continuous contention from k requesters, each requester waits at most k−1 cycles between grants.

## Test plan
- Single read: preload addr 0x004 = 0x12345678; requester 2 reads 0x004 → `req_ready`[2] high same cycle; `rsp_valid` = 0b0100 for one cycle at accept+2; `rsp_rdata` = 0x12345678.
- Write then read back:
  - Requester 0 writes 0xDEADBEEF to 0x000 with `wstrb` 0xF, then immediately reads 0x000 → `rsp_rdata` = 0xDEADBEEF.
  - Requester 0 then writes 0x000000AA with `wstrb` 0x1, then reads 0x000 → `rsp_rdata` = 0xDEADBEAA.
- Round-robin fairness: all 4 requesters hold continuous reads for 16 cycles from reset → grants in order 0,1,2,3,0,1,… with each requester granted exactly 4 times. Each `rsp_valid` goes to the requester that issued the read, and its `rsp_rdata` matches that read's address.
- Pointer continuity: only requester 3 is valid, then requesters 0 and 3 are valid together → requester 0 is granted first (`rr_ptr` = 0 after the grant to 3), then requester 3.
- Back-to-back routing with `RD_LATENCY`=2: requesters 1, 2, 1 read addresses 0x010, 0x020, 0x030 on consecutive cycles. Expected: three consecutive `rsp_valid` pulses, one per cycle, in order 0b0010, 0b0100, 0b0010, starting at accept+3. Each pulse carries the data for its matching address.
- Reset mid-flight: assert `areset` one cycle after a read is accepted, and release it 3 cycles later. Expected: no `rsp_valid` during or after reset; all outputs at their reset values while `areset` is high; the next command after release is granted starting from index 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares native BRAM port B between NUM_REQ fabric requesters using a
// round-robin grant. BRAM command outputs are registered from the winning
// requester, and a small (valid, id) pipeline routes each read's returning
// data back to the requester that issued it.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            bram_en,
  output logic [DATA_WIDTH/8-1:0]         bram_we,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  output logic [DATA_WIDTH-1:0]           bram_wdata,
  input  logic [DATA_WIDTH-1:0]           bram_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = $clog2(NUM_REQ);
  localparam int PIPE_DEPTH = RD_LATENCY + 1;
  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);

  // Per-requester views of the flattened command buses
  logic [ADDR_WIDTH-1:0] addrSlice  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdataSlice [NUM_REQ];
  logic [STRB_WIDTH-1:0] wstrbSlice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
    assign addrSlice[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdataSlice[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign wstrbSlice[g] = req_wstrb[g*STRB_WIDTH +: STRB_WIDTH];
  end

  // Arbitration state and registered BRAM command
  logic [IDX_WIDTH-1:0]  rrPtr_q,     rrPtr_d;
  logic                  bramEn_q,    bramEn_d;
  logic [STRB_WIDTH-1:0] bramWe_q,    bramWe_d;
  logic [ADDR_WIDTH-1:0] bramAddr_q,  bramAddr_d;
  logic [DATA_WIDTH-1:0] bramWdata_q, bramWdata_d;

  // Read tracking pipeline: stage 0 is loaded at the accept edge
  logic [PIPE_DEPTH-1:0]                rdVld_q;
  logic [PIPE_DEPTH-1:0][IDX_WIDTH-1:0] rdId_q;
  logic                                 rdVld_d;
  logic [IDX_WIDTH-1:0]                 rdId_d;

  // Arbitration search signals
  logic                 grantFound;
  logic [IDX_WIDTH-1:0] grantIdx;
  logic [IDX_WIDTH:0]   candSum;
  logic [IDX_WIDTH-1:0] candIdx;
  logic                 accept;

  // Scan requesters starting at the priority pointer, wrapping at NUM_REQ; first valid wins
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candSum    = '0;
    candIdx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = {1'b0, rrPtr_q} + (IDX_WIDTH + 1)'(k);
      if (candSum >= NUM_REQ_W) begin
        candSum = candSum - NUM_REQ_W;
      end
      candIdx = candSum[IDX_WIDTH-1:0];
      if (!grantFound && req_valid[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  assign accept = grantFound && !areset;

  // One-hot grant back to the winner; silenced while reset is held
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  // Priority moves to the requester just after the winner; holds when idle
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (accept) begin
      if (grantIdx == LAST_IDX) begin
        rrPtr_d = '0;
      end else begin
        rrPtr_d = grantIdx + IDX_WIDTH'(1);
      end
    end
  end

  // Build the next BRAM command from the winner; address and data hold when idle
  always_comb begin
    bramEn_d    = 1'b0;
    bramWe_d    = '0;
    bramAddr_d  = bramAddr_q;
    bramWdata_d = bramWdata_q;
    rdVld_d     = 1'b0;
    rdId_d      = grantIdx;
    if (accept) begin
      bramEn_d    = 1'b1;
      bramAddr_d  = addrSlice[grantIdx];
      bramWdata_d = wdataSlice[grantIdx];
      if (req_we[grantIdx]) begin
        bramWe_d = wstrbSlice[grantIdx];
      end else begin
        rdVld_d = 1'b1;
      end
    end
  end

  // Register pointer and BRAM command so port B sees clean, edge-aligned signals
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rrPtr_q     <= '0;
      bramEn_q    <= 1'b0;
      bramWe_q    <= '0;
      bramAddr_q  <= '0;
      bramWdata_q <= '0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      bramEn_q    <= bramEn_d;
      bramWe_q    <= bramWe_d;
      bramAddr_q  <= bramAddr_d;
      bramWdata_q <= bramWdata_d;
    end
  end

  // Shift read ids alongside the BRAM latency so the tail lines up with returning data
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdVld_q <= '0;
      rdId_q  <= '0;
    end else begin
      rdVld_q <= {rdVld_q[PIPE_DEPTH-2:0], rdVld_d};
      rdId_q  <= {rdId_q[PIPE_DEPTH-2:0], rdId_d};
    end
  end

  // Decode the pipeline tail into a one-hot response strobe
  always_comb begin
    rsp_valid = '0;
    if (rdVld_q[PIPE_DEPTH-1]) begin
      rsp_valid[rdId_q[PIPE_DEPTH-1]] = 1'b1;
    end
  end

  assign rsp_rdata  = bram_rdata;
  assign bram_en    = bramEn_q;
  assign bram_we    = bramWe_q;
  assign bram_addr  = bramAddr_q;
  assign bram_wdata = bramWdata_q;

endmodule
